// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with sub-word read-modify-write and access timeout
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [2:0] MODE_W  = 3'd0;
    localparam logic [2:0] MODE_HS = 3'd1;
    localparam logic [2:0] MODE_HU = 3'd2;
    localparam logic [2:0] MODE_BS = 3'd3;
    localparam logic [2:0] MODE_BU = 3'd4;
    localparam int         CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t        r_state;
    logic          r_load;
    logic [2:0]    r_mode;
    logic [1:0]    r_lane;
    logic [15:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [29:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic          r_resp_err;

    logic          w_req_err;
    logic          w_timeout;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;
    logic [31:0]   w_load_data;
    logic [31:0]   w_merged;

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    assign w_req_err = (req_load == req_store) || (req_mode > MODE_BU)
                    || (((req_mode == MODE_HS) || (req_mode == MODE_HU)) && req_addr[0])
                    || ((req_mode == MODE_W) && (req_addr[1:0] != 2'b00));

    assign w_timeout = (TIMEOUT != 0) && r_mem_req && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));

    assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];

    always_comb begin
        w_load_data = mem_rdata;
        case (r_mode)
            MODE_HS: w_load_data = {{16{w_half[15]}}, w_half};
            MODE_HU: w_load_data = {16'h0000, w_half};
            MODE_BS: w_load_data = {{24{w_byte[7]}}, w_byte};
            MODE_BU: w_load_data = {24'h000000, w_byte};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word just read
    always_comb begin
        w_merged = mem_rdata;
        if ((r_mode == MODE_BS) || (r_mode == MODE_BU))
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_load       <= 1'b0;
            r_mode       <= 3'd0;
            r_lane       <= 2'd0;
            r_wdata      <= 16'h0000;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 30'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_mem_req && !mem_ack)
                r_cnt <= r_cnt + CW'(1);
            if (w_timeout) begin
                r_state      <= S_RESP;
                r_mem_req    <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (req_valid) begin
                            r_load  <= req_load;
                            r_mode  <= req_mode;
                            r_lane  <= req_addr[1:0];
                            r_wdata <= req_wdata[15:0];
                            if (w_req_err) begin
                                r_state      <= S_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp_rdata <= 32'd0;
                                r_resp_err   <= 1'b1;
                            end else begin
                                r_mem_addr <= req_addr[31:2];
                                r_mem_req  <= 1'b1;
                                r_cnt      <= '0;
                                if (req_load || (req_mode != MODE_W)) begin
                                    r_state  <= S_READ;
                                    r_mem_we <= 1'b0;
                                end else begin
                                    r_state     <= S_WRITE;
                                    r_mem_we    <= 1'b1;
                                    r_mem_wdata <= req_wdata;
                                end
                            end
                        end
                    end
                    S_READ: begin
                        if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            if (r_load) begin
                                r_state      <= S_RESP;
                                r_resp_valid <= 1'b1;
                                r_resp_rdata <= w_load_data;
                                r_resp_err   <= 1'b0;
                            end else begin
                                // mem_req stays low for one cycle before the write phase starts
                                r_state     <= S_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= w_merged;
                                r_cnt       <= '0;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (!r_mem_req) begin
                            r_mem_req <= 1'b1;
                        end else if (mem_ack) begin
                            r_mem_req    <= 1'b0;
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_resp_err   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a variable-latency memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          t_acc = 0;
    logic [15:0] trace;
    int          n_rd;
    int          n_wr;
    string       cur_tag = "reset";

    logic [31:0] mem [0:15];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    int          wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    assign mem_ack   = mem_req && ack_en && (wcnt >= ack_delay);
    assign mem_rdata = (mem_addr[29:4] == 26'd0) ? mem[mem_addr[3:0]] : 32'h0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
        if (mem_req && mem_ack && mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    end

    logic        p_req = 1'b0;
    logic        p_we;
    logic [29:0] p_addr;
    logic [31:0] p_wdata;

    always @(negedge clk) begin : monitor
        int   idx;
        exp_t e;
        idx = cyc - t_acc;
        if (idx >= 0 && idx < 16) trace[idx] = mem_req;
        if (mem_req && mem_ack) begin
            if (mem_we) n_wr++;
            else        n_rd++;
        end
        if (!reset && mem_req && p_req) begin
            chk({cur_tag, "_hold_addr"}, {2'b00, mem_addr}, {2'b00, p_addr});
            chk({cur_tag, "_hold_we"}, {31'd0, mem_we}, {31'd0, p_we});
            chk({cur_tag, "_hold_wdata"}, mem_wdata, p_wdata);
        end
        p_req   = mem_req;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk({cur_tag, "_unexpected_resp"}, {31'd0, resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({cur_tag, "_rdata"}, resp_rdata, e.rdata);
                chk({cur_tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                chk({cur_tag, "_latency"}, idx, e.lat);
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wd);
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wd;
        for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        chk({cur_tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        t_acc = cyc;
        trace = 16'h0;
        n_rd  = 0;
        n_wr  = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic ld, input logic st, input logic [2:0] mode,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input logic [15:0] exp_trace, input int exp_rd, input int exp_wr);
        exp_t e;
        int   k;
        cur_tag = tag;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        drive(ld, st, mode, addr, wd);
        for (k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk({tag, "_resp_timeout"}, sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        chk({tag, "_req_trace"}, {16'h0, trace}, {16'h0, exp_trace});
        chk({tag, "_reads"}, n_rd, exp_rd);
        chk({tag, "_writes"}, n_wr, exp_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4]    = 32'h8899AABB;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        req_mode  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

        // Loads with every extension mode, zero-wait memory
        do_req("lb_11",  1, 0, 3'd3, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2, 16'h0002, 1, 0);
        do_req("lbu_13", 1, 0, 3'd4, 32'h13, 32'h0, 32'h00000088, 0, 2, 16'h0002, 1, 0);
        do_req("lhu_12", 1, 0, 3'd2, 32'h12, 32'h0, 32'h00008899, 0, 2, 16'h0002, 1, 0);
        do_req("lh_10",  1, 0, 3'd1, 32'h10, 32'h0, 32'hFFFFAABB, 0, 2, 16'h0002, 1, 0);
        do_req("lw_10",  1, 0, 3'd0, 32'h10, 32'h0, 32'h8899AABB, 0, 2, 16'h0002, 1, 0);

        // Sub-word stores: read, one idle cycle, write
        do_req("sh_12", 0, 1, 3'd1, 32'h12, 32'h00001234, 32'h0, 0, 4, 16'h000A, 1, 1);
        chk("sh_12_mem", mem[4], 32'h1234AABB);
        do_req("sb_11", 0, 1, 3'd4, 32'h11, 32'hFFFFFF5A, 32'h0, 0, 4, 16'h000A, 1, 1);
        chk("sb_11_mem", mem[4], 32'h12345ABB);
        do_req("sw_10", 0, 1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 16'h0002, 0, 1);
        chk("sw_10_mem", mem[4], 32'hDEADBEEF);
        mem[4] = 32'h8899AABB;

        // Request errors never touch memory
        do_req("err_lw_06",  1, 0, 3'd0, 32'h06, 32'h0, 32'h0, 1, 1, 16'h0000, 0, 0);
        do_req("err_sh_13",  0, 1, 3'd1, 32'h13, 32'h0, 32'h0, 1, 1, 16'h0000, 0, 0);
        do_req("err_mode5",  1, 0, 3'd5, 32'h10, 32'h0, 32'h0, 1, 1, 16'h0000, 0, 0);
        do_req("err_ldst",   1, 1, 3'd0, 32'h10, 32'h0, 32'h0, 1, 1, 16'h0000, 0, 0);
        do_req("err_noop",   0, 0, 3'd0, 32'h10, 32'h0, 32'h0, 1, 1, 16'h0000, 0, 0);
        chk("err_mem_intact", mem[4], 32'h8899AABB);

        // Ack delayed three cycles
        ack_delay = 3;
        do_req("lw_slow", 1, 0, 3'd0, 32'h10, 32'h0, 32'h8899AABB, 0, 5, 16'h001E, 1, 0);
        ack_delay = 0;

        // No ack at all: aborts after TIMEOUT cycles, then unit recovers
        ack_en = 1'b0;
        do_req("lw_timeout", 1, 0, 3'd0, 32'h10, 32'h0, 32'h0, 1, 5, 16'h001E, 0, 0);
        ack_en = 1'b1;
        do_req("lw_after_to", 1, 0, 3'd3, 32'h12, 32'h0, 32'hFFFFFF99, 0, 2, 16'h0002, 1, 0);

        // Reset during the write phase of a sub-word store
        cur_tag   = "rst_mid";
        ack_delay = 2;
        drive(0, 1, 3'd3, 32'h10, 32'h00000077);
        for (k = 0; k < 20 && !(mem_req && mem_we); k++) @(negedge clk);
        chk("rst_mid_in_write", {31'd0, mem_req && mem_we}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_mem_req2", {31'd0, mem_req}, 32'd0);
        repeat (5) @(negedge clk);
        chk("rst_mid_mem", mem[4], 32'h8899AABB);
        ack_delay = 0;
        do_req("lbu_after_rst", 1, 0, 3'd4, 32'h10, 32'h0, 32'h000000BB, 0, 2, 16'h0002, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
